pattern_scan_ctrl: RTL
======================

// Module: pattern_scan_ctrl
// PURPOSE
//  Sequences the X-position counter to scan a rectangular pattern region line by line.
//  Drives the counter's enable, step mode and load value, and reads its output back to
//  hold, advance or reload it. Tracks the Y line index and reports per-line and per-frame
//  completion. Sits between the pattern configuration regs and the counter instance, which
//  lives in the parent.
// PARAMETERS
//  W        12  coordinate width (X and Y)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   reset, synchronous, active-low
//  start      in   1   1-cycle pulse: latch config, begin frame (ignored while busy)
//  abort      in   1   synchronous abort; returns to IDLE, no done
//  x_start    in   W   first X of each line
//  x_end      in   W   last permitted X of each line (inclusive)
//  step_mode  in   2   01:+1 10:+4 11:+8; 00 treated as 01
//  n_lines    in   W   lines per frame; 0 treated as 1
//  pix_ready  in   1   downstream accepts current pixel
//  cnt_val    in   W   counter output (X position)
//  cnt_enb    out  1   counter enable
//  xmode      out  2   counter step select (00 = add 0 = hold/load)
//  load_val   out  W   counter load value
//  y_out      out  W   current line index
//  pix_valid  out  1   cnt_val/y_out form a valid pixel
//  line_done  out  1   1-cycle pulse on last accepted pixel of a line
//  busy       out  1   frame in progress
//  done       out  1   1-cycle pulse after last line
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, y_out=0, latched cfg=0, all outputs 0.
//  Counter contract: next cnt_val = load_val + delta(xmode) when cnt_enb, else 0; 1-cycle latency.
//  IDLE : cnt_enb=0, busy=0. start=1 -> latch x_start/x_end/step/n_lines, y_out<=0, ->LOAD.
//  LOAD : cnt_enb=1, xmode=00, load_val=x_start_q -> counter = x_start next cycle; ->RUN.
//  RUN  : pix_valid=1, cnt_enb=1, load_val=cnt_val (feedback).
//    pix_ready=0 : xmode=00 (X holds), stay.
//    pix_ready=1 and cnt_val+delta <= x_end_q : xmode=step_q, stay.
//    pix_ready=1 and cnt_val+delta >  x_end_q : line_done=1, xmode=00;
//       y_out==n_lines_q-1 -> DONE; else y_out<=y_out+1, ->LOAD.
//  DONE : done=1 one cycle, cnt_enb=0, ->IDLE. busy=1 in LOAD/RUN/DONE.
//  Compare cnt_val+delta at W+1 bits: no X wrap past 2^W-1; line ends instead.
//  x_end_q < x_start_q: each line emits exactly one pixel (x_start).
//  start while busy: ignored; cfg ports changes mid-frame have no effect.
//  abort (any state, priority over all else): ->IDLE next cycle, y_out<=0, no done/line_done.
//  rst_n low mid-frame: same as reset; abort and rst_n both low -> reset wins.
//  Throughput: 1 pixel/cycle in RUN with pix_ready=1; 1 bubble (LOAD) per line.
// STRUCTURE
//  Shared pkg: state enum {IDLE,LOAD,RUN,DONE}, step encodings XM_HOLD/XM_1/XM_4/XM_8,
//   function step_delta(mode) returning 0/1/4/8 (same table as the counter).
//  No sub-module; counter instantiated alongside in the parent, cnt_val looped back.
// TESTING (bench instantiates real counter)
//  x_start=0,x_end=7,step=01,n_lines=1,ready=1 -> X 0..7 on pix_valid, line_done with X=7, done 1 cycle later.
//  x_start=2,x_end=20,step=10,n_lines=3 -> per line X 2,6,10,14,18; y 0,1,2; 1 bubble between lines; done once.
//  pix_ready toggled 1/0 each cycle, step=11, 0..31 -> X 0,8,16,24 each held 2 cycles, none skipped.
//  x_start=4090,x_end=4095,step=11 -> single pixel X=4090 per line, no wrap to low X.
//  abort during line 1 of 3 -> IDLE next cycle, cnt_enb=0, no done; new start runs full frame from y=0.
//  rst_n low mid-RUN, start pulsed while busy, step_mode=00 -> reset values; start ignored; steps of +1.

Source files
------------

// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg: shared FSM states and X-counter step encodings for the pattern scanner.
package pattern_scan_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [1:0] XM_HOLD = 2'b00;
    localparam logic [1:0] XM_1    = 2'b01;
    localparam logic [1:0] XM_4    = 2'b10;
    localparam logic [1:0] XM_8    = 2'b11;
    function automatic logic [3:0] step_delta(input logic [1:0] mode);
        return mode == XM_1 ? 4'd1 : mode == XM_4 ? 4'd4 : mode == XM_8 ? 4'd8 : 4'd0;
    endfunction
endpackage

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: drives an external X counter line by line over a rectangular region,
// tracking the Y line and flagging line and frame completion.
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] x_start,
    input  logic [W-1:0] x_end,
    input  logic [1:0]   step_mode,
    input  logic [W-1:0] n_lines,
    input  logic         pix_ready,
    input  logic [W-1:0] cnt_val,
    output logic         cnt_enb,
    output logic [1:0]   xmode,
    output logic [W-1:0] load_val,
    output logic [W-1:0] y_out,
    output logic         pix_valid,
    output logic         line_done,
    output logic         busy,
    output logic         done
);
    state_t       state, state_nxt;
    logic [W-1:0] y_q, xs_q, xe_q, nl_q;
    logic [1:0]   step_q;
    logic [W:0]   x_nxt;
    logic         last_x, last_y;
    // One extra bit so a step past 2^W-1 ends the line instead of wrapping to low X.
    assign x_nxt  = {1'b0, cnt_val} + {{(W-3){1'b0}}, step_delta(step_q)};
    assign last_x = x_nxt > {1'b0, xe_q};
    assign last_y = y_q == nl_q - W'(1);
    assign y_out  = y_q;
    always_comb begin
        state_nxt = state;
        cnt_enb   = 1'b0;
        xmode     = XM_HOLD;
        load_val  = '0;
        pix_valid = 1'b0;
        line_done = 1'b0;
        done      = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE: state_nxt = start ? LOAD : IDLE;
            LOAD: begin
                cnt_enb   = 1'b1;
                load_val  = xs_q;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_enb   = 1'b1;
                pix_valid = 1'b1;
                load_val  = cnt_val;
                if (pix_ready && !last_x) xmode = step_q;
                if (pix_ready && last_x) begin
                    line_done = !abort;
                    state_nxt = last_y ? DONE : LOAD;
                end
            end
            DONE: begin
                done      = !abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            y_q    <= '0;
            xs_q   <= '0;
            xe_q   <= '0;
            nl_q   <= '0;
            step_q <= XM_HOLD;
        end else begin
            state <= state_nxt;
            if (abort) begin
                y_q <= '0;
            end else if (state == IDLE && start) begin
                y_q    <= '0;
                xs_q   <= x_start;
                xe_q   <= x_end;
                nl_q   <= n_lines == '0 ? W'(1) : n_lines;
                step_q <= step_mode == XM_HOLD ? XM_1 : step_mode;
            end else if (state == RUN && pix_ready && last_x && !last_y) begin
                y_q <= y_q + W'(1);
            end
        end
    end
endmodule
